// File: rtl/serial_console_bridge_pkg.sv
// Shared constants for the processor serial console: byte width, default FIFO depth,
// and status bit positions reserved for the data_memory status word.
package serial_pkg;
  localparam int BYTE_W             = 8;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  localparam int STAT_RX_VALID_BIT  = 0;
  localparam int STAT_TX_READY_BIT  = 1;
  localparam int STAT_OVERFLOW_BIT  = 2;
  localparam int STAT_UNDERFLOW_BIT = 3;
endpackage

// File: rtl/serial_console_bridge_if.sv
// CPU-side and host-side byte streams of the serial console bridge.
// slave = the bridge; master = the processor/host side driving it.
interface serial_console_bridge_if
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int DATA_W     = BYTE_W
);
  logic [DATA_W-1:0]   serial_in;
  logic                serial_valid_in;
  logic                serial_ready_in;
  logic [DATA_W-1:0]   serial_out;
  logic                serial_rden_out;
  logic                serial_wren_out;
  logic [DATA_W-1:0]   host_rx_data;
  logic                host_rx_valid;
  logic                host_rx_ready;
  logic [DATA_W-1:0]   host_tx_data;
  logic                host_tx_valid;
  logic                host_tx_ready;
  logic [DEPTH_LOG2:0] rx_count;
  logic [DEPTH_LOG2:0] tx_count;
  logic                err_clear;
  logic                overflow_err;
  logic                underflow_err;

  modport slave (
    output serial_in, serial_valid_in, serial_ready_in,
    input  serial_out, serial_rden_out, serial_wren_out,
    input  host_rx_data, host_rx_valid,
    output host_rx_ready,
    output host_tx_data, host_tx_valid,
    input  host_tx_ready,
    output rx_count, tx_count,
    input  err_clear,
    output overflow_err, underflow_err
  );

  modport master (
    input  serial_in, serial_valid_in, serial_ready_in,
    output serial_out, serial_rden_out, serial_wren_out,
    output host_rx_data, host_rx_valid,
    input  host_rx_ready,
    input  host_tx_data, host_tx_valid,
    output host_tx_ready,
    input  rx_count, tx_count,
    output err_clear,
    input  overflow_err, underflow_err
  );
endinterface

// File: rtl/serial_console_bridge_byte_fifo.sv
// Byte FIFO, 1-cycle minimum latency, no empty bypass; full/empty come from the registered
// count only, so a push at full is refused even when a pop happens in the same cycle.
module byte_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int DATA_W     = BYTE_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [DATA_W-1:0]   pushData,
  input  logic                pop,
  output logic [DATA_W-1:0]   headData,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty
);
  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE    = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wrPtr;
  logic [DEPTH_LOG2-1:0] rdPtr;
  logic [DEPTH_LOG2:0]   countQ;
  logic                  pushOk;
  logic                  popOk;

  assign full     = (countQ == FULL_COUNT);
  assign empty    = (countQ == '0);
  assign pushOk   = push && !full;
  assign popOk    = pop && !empty;
  assign count    = countQ;
  assign headData = mem[rdPtr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + PTR_ONE;
      if (popOk)  rdPtr <= rdPtr + PTR_ONE;
      case ({pushOk, popOk})
        2'b10:   countQ <= countQ + CNT_ONE;
        2'b01:   countQ <= countQ - CNT_ONE;
        default: countQ <= countQ;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible because empty data is masked upstream.
  always_ff @(posedge clock) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end
endmodule

// File: rtl/serial_console_bridge.sv
// Device endpoint for the processor serial ports: RX (host->CPU) and TX (CPU->host) byte FIFOs,
// 1-cycle minimum latency each way, ready/valid from registered counts, sticky CPU misuse flags.
module serial_console_bridge
  import serial_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
  parameter int DATA_W     = BYTE_W
) (
  input logic                    clock,
  input logic                    reset,
  serial_console_bridge_if.slave bus
);
  logic [DATA_W-1:0] rxHead;
  logic [DATA_W-1:0] txHead;
  logic              rxFull;
  logic              rxEmpty;
  logic              txFull;
  logic              txEmpty;
  logic              overflowErr;
  logic              underflowErr;

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) rxFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (bus.host_rx_valid),
    .pushData (bus.host_rx_data),
    .pop      (bus.serial_rden_out),
    .headData (rxHead),
    .count    (bus.rx_count),
    .full     (rxFull),
    .empty    (rxEmpty)
  );

  byte_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) txFifo (
    .clock    (clock),
    .reset    (reset),
    .push     (bus.serial_wren_out),
    .pushData (bus.serial_out),
    .pop      (bus.host_tx_ready),
    .headData (txHead),
    .count    (bus.tx_count),
    .full     (txFull),
    .empty    (txEmpty)
  );

  assign bus.serial_in       = rxEmpty ? '0 : rxHead;
  assign bus.serial_valid_in = !rxEmpty;
  assign bus.host_rx_ready   = !rxFull;
  assign bus.host_tx_data    = txEmpty ? '0 : txHead;
  assign bus.host_tx_valid   = !txEmpty;
  assign bus.serial_ready_in = !txFull;

  // A new error event in the same cycle as err_clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset) begin
      overflowErr  <= 1'b0;
      underflowErr <= 1'b0;
    end else begin
      if (bus.serial_wren_out && txFull) overflowErr <= 1'b1;
      else if (bus.err_clear)            overflowErr <= 1'b0;
      if (bus.serial_rden_out && rxEmpty) underflowErr <= 1'b1;
      else if (bus.err_clear)             underflowErr <= 1'b0;
    end
  end

  assign bus.overflow_err  = overflowErr;
  assign bus.underflow_err = underflowErr;
endmodule

// File: tb/tb_serial_console_bridge.sv
// Scoreboard bench for serial_console_bridge: expected bytes are queued as stimulus is driven
// and compared when the bridge hands a byte to the CPU or the host.
module tb_serial_console_bridge;
  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;
  logic [7:0] rxExp[$];
  logic [7:0] txExp[$];
  logic [4:0] maxTx;

  serial_console_bridge_if #(.DEPTH_LOG2(4), .DATA_W(8)) bus ();

  serial_console_bridge #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkVal({tag, "_serial_valid"}, 32'(bus.serial_valid_in), 0);
    checkVal({tag, "_serial_in"},    32'(bus.serial_in), 0);
    checkVal({tag, "_tx_valid"},     32'(bus.host_tx_valid), 0);
    checkVal({tag, "_tx_data"},      32'(bus.host_tx_data), 0);
    checkVal({tag, "_serial_ready"}, 32'(bus.serial_ready_in), 1);
    checkVal({tag, "_rx_ready"},     32'(bus.host_rx_ready), 1);
    checkVal({tag, "_rx_count"},     32'(bus.rx_count), 0);
    checkVal({tag, "_tx_count"},     32'(bus.tx_count), 0);
    checkVal({tag, "_ovf"},          32'(bus.overflow_err), 0);
    checkVal({tag, "_unf"},          32'(bus.underflow_err), 0);
  endtask

  // Byte handovers are judged mid-cycle, ahead of the edge that performs them.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.tx_count > maxTx) maxTx = bus.tx_count;
      if (bus.serial_rden_out && bus.serial_valid_in) begin
        checkVal("rx_pending", 32'(rxExp.size() != 0), 1);
        if (rxExp.size() != 0) checkVal("rx_byte", 32'(bus.serial_in), 32'(rxExp.pop_front()));
      end
      if (bus.host_tx_ready && bus.host_tx_valid) begin
        checkVal("tx_pending", 32'(txExp.size() != 0), 1);
        if (txExp.size() != 0) checkVal("tx_byte", 32'(bus.host_tx_data), 32'(txExp.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] hello [3];
    int idx;
    int n;
    vectors = 0;
    miscompares = 0;
    maxTx = '0;
    hello[0] = 8'h48; hello[1] = 8'h69; hello[2] = 8'h0A;
    reset = 1'b1;
    bus.serial_out = '0; bus.serial_rden_out = 0; bus.serial_wren_out = 0;
    bus.host_rx_data = '0; bus.host_rx_valid = 0; bus.host_tx_ready = 0;
    bus.err_clear = 0;
    step();
    step();
    reset = 1'b0;
    checkResetState("rst");

    // RX ordering
    for (int i = 0; i < 3; i++) begin
      bus.host_rx_data = hello[i];
      bus.host_rx_valid = 1;
      rxExp.push_back(hello[i]);
      step();
    end
    bus.host_rx_valid = 0;
    checkVal("rx_count3", 32'(bus.rx_count), 3);
    bus.serial_rden_out = 1;
    repeat (3) step();
    bus.serial_rden_out = 0;
    checkVal("rx_empty_valid", 32'(bus.serial_valid_in), 0);
    checkVal("rx_empty_data", 32'(bus.serial_in), 0);
    checkVal("rx_no_unf", 32'(bus.underflow_err), 0);

    // TX backpressure and overflow
    for (int i = 0; i < 16; i++) begin
      bus.serial_out = 8'(i);
      bus.serial_wren_out = 1;
      txExp.push_back(8'(i));
      step();
      if (i == 14) checkVal("tx_ready_at15", 32'(bus.serial_ready_in), 1);
    end
    checkVal("tx_ready_full", 32'(bus.serial_ready_in), 0);
    checkVal("tx_count_full", 32'(bus.tx_count), 16);
    bus.serial_out = 8'hFF;
    step();
    bus.serial_wren_out = 0;
    checkVal("tx_ovf_set", 32'(bus.overflow_err), 1);
    checkVal("tx_count_keep", 32'(bus.tx_count), 16);
    bus.host_tx_ready = 1;
    n = 0;
    while (bus.tx_count != 0 && n < 40) begin step(); n++; end
    bus.host_tx_ready = 0;
    checkVal("tx_drain_in_time", 32'(n < 40), 1);
    checkVal("tx_queue_done", 32'(txExp.size()), 0);
    checkVal("tx_ovf_sticky", 32'(bus.overflow_err), 1);
    bus.err_clear = 1;
    step();
    bus.err_clear = 0;
    checkVal("tx_ovf_cleared", 32'(bus.overflow_err), 0);

    // RX full with simultaneous push and pop
    for (int i = 0; i < 16; i++) begin
      bus.host_rx_data = 8'(8'h80 + i);
      bus.host_rx_valid = 1;
      rxExp.push_back(8'(8'h80 + i));
      step();
    end
    checkVal("rx_ready_full", 32'(bus.host_rx_ready), 0);
    checkVal("rx_count_full", 32'(bus.rx_count), 16);
    bus.host_rx_data = 8'hEE;
    bus.serial_rden_out = 1;
    step();
    bus.host_rx_valid = 0;
    bus.serial_rden_out = 0;
    checkVal("rx_full_popcount", 32'(bus.rx_count), 15);
    checkVal("rx_ready_after_pop", 32'(bus.host_rx_ready), 1);
    bus.serial_rden_out = 1;
    repeat (15) step();
    bus.serial_rden_out = 0;
    checkVal("rx_drained", 32'(bus.rx_count), 0);

    // Empty read, clear, and set-beats-clear
    bus.serial_rden_out = 1;
    step();
    bus.serial_rden_out = 0;
    checkVal("unf_set", 32'(bus.underflow_err), 1);
    checkVal("unf_rx_count", 32'(bus.rx_count), 0);
    checkVal("unf_no_ovf", 32'(bus.overflow_err), 0);
    bus.err_clear = 1;
    step();
    checkVal("unf_cleared", 32'(bus.underflow_err), 0);
    bus.serial_rden_out = 1;
    step();
    bus.serial_rden_out = 0;
    checkVal("unf_set_wins", 32'(bus.underflow_err), 1);
    step();
    bus.err_clear = 0;
    checkVal("unf_cleared2", 32'(bus.underflow_err), 0);

    // Wrap-around with host accepting every other cycle
    idx = 0;
    n = 0;
    while ((idx < 40 || txExp.size() != 0) && n < 400) begin
      bus.host_tx_ready = n[0];
      if (idx < 40 && bus.serial_ready_in) begin
        bus.serial_out = 8'(8'h10 + idx);
        bus.serial_wren_out = 1;
        txExp.push_back(8'(8'h10 + idx));
        idx++;
      end else begin
        bus.serial_wren_out = 0;
      end
      step();
      n++;
    end
    bus.serial_wren_out = 0;
    bus.host_tx_ready = 0;
    step();
    checkVal("wrap_in_time", 32'(n < 400), 1);
    checkVal("wrap_all_sent", 32'(idx), 40);
    checkVal("wrap_queue_done", 32'(txExp.size()), 0);
    checkVal("wrap_tx_count", 32'(bus.tx_count), 0);
    checkVal("wrap_max_count", 32'(maxTx <= 5'd16), 1);
    checkVal("wrap_max_reached", 32'(maxTx), 16);
    checkVal("wrap_no_ovf", 32'(bus.overflow_err), 0);

    // Reset mid-operation discards everything; reset beats a same-cycle push
    for (int i = 0; i < 5; i++) begin
      bus.host_rx_data = 8'(8'h60 + i);
      bus.host_rx_valid = 1;
      bus.serial_out = 8'(8'h70 + i);
      bus.serial_wren_out = (i < 3);
      step();
    end
    bus.serial_wren_out = 0;
    checkVal("pre_rst_rx", 32'(bus.rx_count), 5);
    checkVal("pre_rst_tx", 32'(bus.tx_count), 3);
    bus.host_rx_data = 8'h11;
    bus.serial_rden_out = 1;
    bus.err_clear = 0;
    reset = 1;
    step();
    reset = 0;
    bus.host_rx_valid = 0;
    bus.serial_rden_out = 0;
    checkResetState("mid_rst");
    bus.host_rx_data = 8'hA5;
    bus.host_rx_valid = 1;
    rxExp.push_back(8'hA5);
    step();
    bus.host_rx_valid = 0;
    checkVal("post_rst_valid", 32'(bus.serial_valid_in), 1);
    checkVal("post_rst_head", 32'(bus.serial_in), 32'h A5);
    bus.serial_rden_out = 1;
    step();
    bus.serial_rden_out = 0;
    checkVal("post_rst_rx_count", 32'(bus.rx_count), 0);
    checkVal("final_rx_queue", 32'(rxExp.size()), 0);
    checkVal("final_tx_queue", 32'(txExp.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_console_bridge.md
Name: serial_console_bridge

Overview:
Device-side endpoint for the processor's serial IO ports. It answers the data_memory serial handshake that the processor initiates. Two byte FIFOs connect a host byte stream (testbench, UART core or JTAG shim) to the processor:
- RX path: host bytes are buffered and presented to the CPU on serial_in/serial_valid_in, and popped by serial_rden_out.
- TX path: CPU bytes written with serial_wren_out are buffered and drained to the host over a valid/ready stream.

Parameters:
DEPTH_LOG2, 4, log2 of each FIFO depth (default 16 entries); both FIFOs use the same depth.
DATA_W, 8, byte width; fixed at 8 for the processor interface.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
serial_in  output  DATA_W  RX FIFO head byte to processor; 0 when empty
serial_valid_in  output  1  RX FIFO non-empty
serial_ready_in  output  1  TX FIFO not full
serial_out  input  DATA_W  byte written by processor
serial_rden_out  input  1  processor pops RX head this cycle
serial_wren_out  input  1  processor pushes serial_out this cycle
host_rx_data  input  DATA_W  byte from host
host_rx_valid  input  1  host offers host_rx_data
host_rx_ready  output  1  RX FIFO not full
host_tx_data  output  DATA_W  TX FIFO head byte to host; 0 when empty
host_tx_valid  output  1  TX FIFO non-empty
host_tx_ready  input  1  host accepts host_tx_data
rx_count  output  DEPTH_LOG2+1  RX occupancy
tx_count  output  DEPTH_LOG2+1  TX occupancy
err_clear  input  1  clears sticky error flags
overflow_err  output  1  sticky: CPU wrote while serial_ready_in low
underflow_err  output  1  sticky: CPU read while serial_valid_in low

Behaviour:
- Reset (synchronous, takes priority over all other inputs): FIFO pointers and counts go to 0 and both error flags clear. Outputs after reset: serial_valid_in=0, host_tx_valid=0, serial_in=0, host_tx_data=0, serial_ready_in=1, host_rx_ready=1, rx_count=0, tx_count=0. Reset mid-transfer discards all buffered bytes. No partial state survives.
- Push transfer: occurs on a rising edge where valid/wren=1 and the corresponding ready/not-full=1.
- Pop transfer: occurs on a rising edge where rden or host_tx_ready=1 and the FIFO is non-empty.
- Status outputs (valid, ready, counts) derive only from registered count. They never depend combinationally on same-cycle handshake inputs, so there is no comb path from input handshakes to output handshakes.
- Latency: a byte pushed at edge N is visible, with valid=1, in the cycle after N. A byte takes a minimum of 1 cycle to cross each FIFO; there is no bypass when empty.
- Simultaneous push and pop, FIFO non-empty and not full: both occur and count is unchanged.
- Full FIFO: ready=0, so no push, even if a pop occurs in the same cycle. Ready rises in the cycle after the pop.
- Empty FIFO: valid=0 and the data output is 0. A same-cycle push plus pop request performs only the push.
- CPU write while serial_ready_in=0: the byte is dropped, overflow_err is set next cycle, and tx_count is unchanged.
- CPU rden while serial_valid_in=0: ignored; underflow_err is set next cycle.
- err_clear=1: both flags clear next cycle. If an error event occurs in the same cycle, the set wins.
- Host-side protocol violations (e.g. valid while not ready) are not errors. The offered byte is simply not transferred.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Count ranges 0..2^DEPTH_LOG2.
- Byte ordering is strictly FIFO per direction. RX and TX are fully independent.

Decomposition:
- Shared package serial_pkg holds:
  - BYTE_W=8
  - the default depth constant
  - the serial status bit positions, for later memory-mapped exposure through data_memory.
- One natural sub-module, byte_fifo (parameter DEPTH_LOG2), provides:
  - push/push_ok and pop/pop_ok
  - head data, count, full, empty
- byte_fifo is instantiated twice, once for RX and once for TX. The top level adds only the error flags and the zeroing of empty data.

Test Plan:
- RX ordering: host pushes 0x48, 0x69, 0x0A on consecutive cycles, CPU idle → rx_count=3. Then the CPU pops 3 times → serial_in shows 0x48, 0x69, 0x0A in order, then serial_valid_in=0 and serial_in=0.
- TX backpressure: host_tx_ready=0 and the CPU writes 0x00..0x0F → serial_ready_in falls after the 16th write. A 17th write of 0xFF is dropped and sets overflow_err. With host_tx_ready=1, the host receives exactly 0x00..0x0F.
- Simultaneous push/pop at full: RX holds 16 bytes, host_rx_valid=1 and serial_rden_out=1 in the same cycle → pop only, rx_count=15. host_rx_ready=1 the next cycle.
- Empty read: serial_rden_out=1 with the RX FIFO empty → underflow_err=1 next cycle and rx_count stays 0. err_clear pulse → flag back to 0.
- Wrap-around: stream 40 bytes 0x10..0x37 through TX, with the host accepting every other cycle → all 40 bytes arrive in order, tx_count never exceeds 16, and no overflow_err.
- Reset mid-operation: RX holds 5 bytes and TX holds 3, then reset for 1 cycle → all outputs at their reset values next cycle. A new host byte 0xA5 is read first by the CPU.
